// File: rtl/semaforo_pkg.sv
// Shared types and constants for the four-way traffic-light sequencer.
// Light i occupies bits [3i+2:3i] = {red, yellow, green}.
package semaforo_pkg;

   typedef enum logic [2:0] {
      ALL_RED_A = 3'd0,
      NS_GREEN  = 3'd1,
      NS_YELLOW = 3'd2,
      ALL_RED_B = 3'd3,
      EW_GREEN  = 3'd4,
      EW_YELLOW = 3'd5,
      FLASH     = 3'd6
   } state_t;

   localparam int unsigned GRN_OFS  = 0;
   localparam int unsigned YEL_OFS  = 1;
   localparam int unsigned RED_OFS  = 2;
   localparam int unsigned NS_LIGHT_A = 0;
   localparam int unsigned NS_LIGHT_B = 2;
   localparam int unsigned EW_LIGHT_A = 1;
   localparam int unsigned EW_LIGHT_B = 3;

   localparam logic [11:0] ALL_RED  = 12'h924;
   localparam logic [11:0] NS_GRN   = 12'h861;
   localparam logic [11:0] NS_YEL   = 12'h8A2;
   localparam logic [11:0] EW_GRN   = 12'h30C;
   localparam logic [11:0] EW_YEL   = 12'h514;
   localparam logic [11:0] FLASH_ON = 12'h492;

   function automatic logic [11:0] pattern(input state_t s);
      case (s)
         NS_GREEN:  return NS_GRN;
         NS_YELLOW: return NS_YEL;
         EW_GREEN:  return EW_GRN;
         EW_YELLOW: return EW_YEL;
         FLASH:     return FLASH_ON;
         default:   return ALL_RED;
      endcase
   endfunction

endpackage

// File: rtl/semaforo_ctrl_tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV enabled cycles.
module tick_prescaler #(
   parameter int unsigned TICK_DIV = 50_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (en) begin
         if (cnt == LAST) cnt <= '0;
         else             cnt <= cnt + 1'b1;
      end
   end

   assign tick = en && (cnt == LAST);

endmodule

// File: rtl/semaforo_ctrl.sv
// Traffic-light phase sequencer: tick timer, pedestrian latch, night flash
// and registered light/phase outputs with a phase_start trigger strobe.
module semaforo_ctrl
   import semaforo_pkg::*;
#(
   parameter int unsigned TICK_DIV  = 50_000_000,
   parameter int unsigned GREEN_T   = 20,
   parameter int unsigned YELLOW_T  = 3,
   parameter int unsigned ALLRED_T  = 2,
   parameter int unsigned MIN_GREEN = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        ped_req,
   input  logic        night_mode,
   output logic [11:0] semaforos,
   output logic [2:0]  phase,
   output logic        phase_start
);

   localparam int unsigned MAX_GY = (GREEN_T > YELLOW_T) ? GREEN_T : YELLOW_T;
   localparam int unsigned MAX_T  = (MAX_GY > ALLRED_T) ? MAX_GY : ALLRED_T;
   localparam int unsigned TW     = (MAX_T > 2) ? $clog2(MAX_T) : 1;

   state_t        state;
   state_t        nxt;
   logic [TW-1:0] timer;
   logic [TW-1:0] last_cnt;
   logic          ped_pend;
   logic          flash_on;
   logic          tick;
   logic          green;
   logic          cut;
   logic          advance;

   tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .tick (tick)
   );

   always_comb begin
      last_cnt = '0;
      nxt      = ALL_RED_A;
      case (state)
         ALL_RED_A: begin last_cnt = TW'(ALLRED_T - 1); nxt = NS_GREEN;  end
         NS_GREEN:  begin last_cnt = TW'(GREEN_T - 1);  nxt = NS_YELLOW; end
         NS_YELLOW: begin last_cnt = TW'(YELLOW_T - 1); nxt = ALL_RED_B; end
         ALL_RED_B: begin last_cnt = TW'(ALLRED_T - 1); nxt = EW_GREEN;  end
         EW_GREEN:  begin last_cnt = TW'(GREEN_T - 1);  nxt = EW_YELLOW; end
         EW_YELLOW: begin last_cnt = TW'(YELLOW_T - 1); nxt = ALL_RED_A; end
         default:   begin last_cnt = '0;                nxt = ALL_RED_A; end
      endcase
   end

   assign green   = (state == NS_GREEN) || (state == EW_GREEN);
   assign cut     = green && ped_pend && (timer >= TW'(MIN_GREEN - 1));
   assign advance = (timer == last_cnt) || cut;

   // Entry into an all-red clears the pending request; a request on that same
   // cycle is still captured so it is not lost.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ALL_RED_A;
         timer       <= '0;
         ped_pend    <= 1'b0;
         flash_on    <= 1'b0;
         semaforos   <= ALL_RED;
         phase_start <= 1'b0;
      end else if (!en) begin
         phase_start <= 1'b0;
      end else begin
         phase_start <= 1'b0;
         ped_pend    <= ped_pend | ped_req;
         if (tick) begin
            if (night_mode) begin
               state       <= FLASH;
               timer       <= '0;
               phase_start <= 1'b1;
               if (state == FLASH) begin
                  flash_on  <= !flash_on;
                  semaforos <= flash_on ? '0 : FLASH_ON;
               end else begin
                  flash_on  <= 1'b1;
                  semaforos <= FLASH_ON;
               end
            end else if (state == FLASH) begin
               state       <= ALL_RED_A;
               timer       <= '0;
               phase_start <= 1'b1;
               flash_on    <= 1'b0;
               semaforos   <= ALL_RED;
               ped_pend    <= ped_req;
            end else if (advance) begin
               state       <= nxt;
               timer       <= '0;
               phase_start <= 1'b1;
               semaforos   <= pattern(nxt);
               if (nxt == ALL_RED_A || nxt == ALL_RED_B) ped_pend <= ped_req;
            end else begin
               timer <= timer + 1'b1;
            end
         end
      end
   end

   assign phase = state;

endmodule

// File: tb/tb_semaforo_ctrl.sv
// Scoreboard bench for semaforo_ctrl: a phase-list reference model predicts
// every cycle's outputs; a negedge monitor pops and compares them.
module tb_semaforo_ctrl;

   localparam int unsigned TD = 4;
   localparam int unsigned MG = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic        ped_req = 1'b0;
   logic        night_mode = 1'b0;
   logic [11:0] semaforos;
   logic [2:0]  phase;
   logic        phase_start;

   semaforo_ctrl #(
      .TICK_DIV  (TD),
      .GREEN_T   (5),
      .YELLOW_T  (2),
      .ALLRED_T  (1),
      .MIN_GREEN (MG)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .ped_req     (ped_req),
      .night_mode  (night_mode),
      .semaforos   (semaforos),
      .phase       (phase),
      .phase_start (phase_start)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [11:0] sem;
      logic [2:0]  ph;
      logic        ps;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference: phases 0..5 in a ring, each with a tick count and pattern;
   // phase 6 is the flash mode. Timing held as ticks remaining in the phase.
   int          dur[6] = '{1, 5, 2, 1, 5, 2};
   logic [11:0] pat[6] = '{12'h924, 12'h861, 12'h8A2, 12'h924, 12'h30C, 12'h514};
   int          m_pre, m_ph, m_rem;
   bit          m_ped, m_on, m_ps;
   logic [11:0] m_sem;

   task automatic enter(input int p);
      m_ph  = p;
      m_rem = (p < 6) ? dur[p] : 0;
      m_ps  = 1;
      if (p == 0 || p == 3) m_ped = 0;
   endtask

   task automatic model_step(input bit r, input bit e, input bit p, input bit n);
      bit tk;
      if (r) begin
         m_pre = 0; m_ph = 0; m_rem = dur[0]; m_ped = 0; m_on = 0; m_ps = 0;
         m_sem = 12'h924;
         return;
      end
      m_ps = 0;
      if (!e) return;
      tk    = (m_pre == TD - 1);
      m_pre = tk ? 0 : m_pre + 1;
      if (tk) begin
         if (n) begin
            m_on = (m_ph == 6) ? !m_on : 1'b1;
            enter(6);
         end else if (m_ph == 6) begin
            m_on = 0;
            enter(0);
         end else if (m_rem == 1 ||
                      ((m_ph == 1 || m_ph == 4) && m_ped &&
                       (dur[m_ph] - m_rem) >= int'(MG) - 1)) begin
            enter((m_ph + 1) % 6);
         end else begin
            m_rem--;
         end
      end
      if (p) m_ped = 1;
      m_sem = (m_ph == 6) ? (m_on ? 12'h492 : 12'h000) : pat[m_ph];
   endtask

   task automatic cyc(input bit r, input bit e, input bit p, input bit n);
      exp_t x;
      rst = r; en = e; ped_req = p; night_mode = n;
      model_step(r, e, p, n);
      x.sem = m_sem; x.ph = 3'(m_ph); x.ps = m_ps;
      @(posedge clk);
      exp_q.push_back(x);
      #1;
   endtask

   always @(negedge clk) begin
      exp_t x;
      if (exp_q.size() > 0) begin
         x = exp_q.pop_front();
         checks++;
         if (semaforos !== x.sem) begin
            errors++;
            $display("FAIL semaforos t=%0t got %h want %h", $time, semaforos, x.sem);
         end
         checks++;
         if (phase !== x.ph) begin
            errors++;
            $display("FAIL phase t=%0t got %0d want %0d", $time, phase, x.ph);
         end
         checks++;
         if (phase_start !== x.ps) begin
            errors++;
            $display("FAIL phase_start t=%0t got %0b want %0b", $time, phase_start, x.ps);
         end
      end
   end

   initial begin
      bit nt;
      int wait_cyc;
      // reset, then free run over two full cycles
      repeat (3) cyc(1, 1, 0, 0);
      repeat (140) cyc(0, 1, 0, 0);
      // pedestrian cut in NS_GREEN
      repeat (2) cyc(1, 1, 0, 0);
      repeat (5) cyc(0, 1, 0, 0);
      cyc(0, 1, 1, 0);
      repeat (40) cyc(0, 1, 0, 0);
      // night mode entered mid EW_GREEN, held, then dropped
      repeat (2) cyc(1, 1, 0, 0);
      repeat (42) cyc(0, 1, 0, 0);
      repeat (20) cyc(0, 1, 0, 1);
      repeat (12) cyc(0, 1, 0, 0);
      // enable dropped mid NS_YELLOW
      repeat (2) cyc(1, 1, 0, 0);
      repeat (26) cyc(0, 1, 0, 0);
      repeat (10) cyc(0, 0, 0, 0);
      repeat (20) cyc(0, 1, 0, 0);
      // reset mid EW_YELLOW with a request pending, then full green
      repeat (2) cyc(1, 1, 0, 0);
      repeat (50) cyc(0, 1, 0, 0);
      cyc(0, 1, 1, 0);
      repeat (3) cyc(0, 1, 0, 0);
      cyc(1, 1, 0, 0);
      repeat (40) cyc(0, 1, 0, 0);
      // night mode coinciding with a pedestrian cut tick
      repeat (2) cyc(1, 1, 0, 0);
      cyc(0, 1, 1, 0);
      repeat (9) cyc(0, 1, 0, 0);
      repeat (8) cyc(0, 1, 0, 1);
      repeat (20) cyc(0, 1, 0, 0);
      // randomized traffic
      nt = 0;
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 79) == 0) nt = !nt;
         cyc($urandom_range(0, 399) == 0, $urandom_range(0, 7) != 0,
             $urandom_range(0, 15) == 0, nt);
      end
      cyc(0, 1, 0, 0);
      wait_cyc = 0;
      while (exp_q.size() > 0 && wait_cyc < 10) begin
         @(posedge clk);
         wait_cyc++;
      end
      @(posedge clk);
      if (exp_q.size() > 0) begin
         errors++;
         $display("FAIL drain left %0d want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
